// File: rtl/mult_share_ctrl_pkg.sv
// mult_ctrl_pkg: shared state/step types and the partial-product shift map for mult_share_ctrl
package mult_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  localparam int NUM_STEPS = 4;
  typedef logic [1:0] step_t;
  function automatic int unsigned step_shift(step_t s, int unsigned half);
    return (32'(s[1]) + 32'(s[0])) * half;
  endfunction
endpackage

// File: rtl/mult_share_ctrl_if.sv
// mult_share_ctrl_if: two request ports plus the tagged response port of the shared multiplier
interface mult_share_ctrl_if #(parameter int WIDTH = 32);
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic resp_valid, resp_ready, resp_id, busy;
  logic [2*WIDTH-1:0] resp_data;
  modport master (output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, resp_ready,
                  input req0_ready, req1_ready, resp_valid, resp_data, resp_id, busy);
  modport slave (input req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, resp_ready,
                 output req0_ready, req1_ready, resp_valid, resp_data, resp_id, busy);
endinterface

// File: rtl/mult_engine.sv
// mult_engine: combinational unsigned WIDTH x WIDTH multiplier
module mult_engine #(parameter int WIDTH = 16) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);
  assign p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
endmodule

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter; pointer favours the requester not served last
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       grant_id
);
  logic ptr;
  always_comb begin
    grant_id = &req ? ptr : req[1];
    grant = ~|req ? 2'b00 : (grant_id ? 2'b10 : 2'b01);
  end
  always_ff @(posedge clk) begin
    if (rst) ptr <= 1'b0;
    else if (advance) ptr <= ~grant_id;
  end
endmodule

// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: sequences one half-width multiplier over four steps to serve two requesters
module mult_share_ctrl #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst,
  mult_share_ctrl_if.slave bus
);
  import mult_ctrl_pkg::*;
  localparam int HALF = WIDTH / 2;
  state_t state, state_nx;
  step_t step;
  logic [WIDTH-1:0] a_q, b_q, pp;
  logic [HALF-1:0] op_a, op_b;
  logic [2*WIDTH-1:0] acc;
  logic [1:0] grant;
  logic id_q, grant_id, accept;
  rr_arb2 u_arb (
    .clk(clk), .rst(rst), .req({bus.req1_valid, bus.req0_valid}),
    .advance(accept), .grant(grant), .grant_id(grant_id)
  );
  // step[1] picks the multiplicand half, step[0] the multiplier half
  assign op_a = step[1] ? a_q[WIDTH-1:HALF] : a_q[HALF-1:0];
  assign op_b = step[0] ? b_q[WIDTH-1:HALF] : b_q[HALF-1:0];
  mult_engine #(.WIDTH(HALF)) u_mul (.a(op_a), .b(op_b), .p(pp));
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = (state == IDLE && accept) ? MUL :
               (state == MUL && step == 2'(NUM_STEPS - 1)) ? DONE :
               (state == DONE && bus.resp_ready) ? IDLE : state;
  end
  always_comb begin
    accept = state == IDLE && |grant;
    bus.req0_ready = state == IDLE && grant[0];
    bus.req1_ready = state == IDLE && grant[1];
    bus.resp_valid = state == DONE;
    bus.busy = state != IDLE;
    bus.resp_data = acc;
    bus.resp_id = id_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      id_q <= 1'b0;
      acc <= '0;
      step <= '0;
    end else if (accept) begin
      a_q <= grant_id ? bus.req1_a : bus.req0_a;
      b_q <= grant_id ? bus.req1_b : bus.req0_b;
      id_q <= grant_id;
      acc <= '0;
      step <= '0;
    end else if (state == MUL) begin
      acc <= acc + ({{WIDTH{1'b0}}, pp} << step_shift(step, HALF));
      step <= step + 2'd1;
    end
  end
endmodule
